// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a 2**width-entry register file
// (synchronous write, combinational read) into a synchronous FIFO.
module fifo_ctrl #(
  parameter int width            = 4,
  parameter int almost_full_lvl  = 2**width - 2,
  parameter int almost_empty_lvl = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  output logic             w_en,
  output logic [width-1:0] w_addr,
  output logic [width-1:0] r_addr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [width:0]   count,
  output logic             overflow,
  underflow
);

  localparam logic [width:0]   depth   = (width+1)'(2**width);
  localparam logic [width:0]   af_lvl  = (width+1)'(almost_full_lvl);
  localparam logic [width:0]   ae_lvl  = (width+1)'(almost_empty_lvl);
  localparam logic [width:0]   cnt_one = (width+1)'(1);
  localparam logic [width-1:0] ptr_one = width'(1);

  logic [width-1:0] w_ptr;
  logic [width-1:0] r_ptr;
  logic [width:0]   count_next;
  logic             wr_ok;
  logic             rd_ok;

  // A write while full is accepted only when a read frees the head slot
  // in the same cycle; the array returns the old entry before the edge.
  always_comb begin
    wr_ok      = wr & (~full | rd);
    rd_ok      = rd & ~empty;
    w_en       = wr_ok & ~reset;
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + cnt_one;
      2'b01:   count_next = count - cnt_one;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + ptr_one;
      if (rd_ok) r_ptr <= r_ptr + ptr_one;
      count     <= count_next;
      full      <= (count_next == depth);
      empty     <= (count_next == '0);
      overflow  <= wr & full & ~rd;
      underflow <= rd & empty;
    end
  end

  always_comb begin
    w_addr       = w_ptr;
    r_addr       = r_ptr;
    almost_full  = (count >= af_lvl);
    almost_empty = (count <= ae_lvl);
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed + random bench for fifo_ctrl with a bench-side storage array
// and a queue-based reference FIFO.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, rd;
  logic       w_en;
  logic [3:0] w_addr, r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [16];

  int compares = 0;
  int fails    = 0;

  logic [7:0] q[$];
  int wcnt = 0;
  int rcnt = 0;

  fifo_ctrl #(.width(4), .almost_full_lvl(14), .almost_empty_lvl(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input bit exp_ovf, input bit exp_unf);
    int n;
    n = q.size();
    chk("count", count, n);
    chk("full", full, n == 16);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= 14);
    chk("almost_empty", almost_empty, n <= 1);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
    chk("w_addr_post", w_addr, wcnt % 16);
    chk("r_addr_post", r_addr, rcnt % 16);
  endtask

  // One clock cycle of traffic; called at posedge+1 and returns at posedge+1.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    int n;
    bit ok_w, ok_r;
    n    = q.size();
    wr   = w;
    rd   = r;
    w_data = d;
    ok_w = w && (n < 16 || r);
    ok_r = r && (n > 0);
    #1;
    chk("w_en", w_en, ok_w);
    chk("w_addr", w_addr, wcnt % 16);
    chk("r_addr", r_addr, rcnt % 16);
    if (ok_r) chk("r_data", r_data, q[0]);
    @(posedge clk);
    #1;
    if (ok_r) void'(q.pop_front());
    if (ok_w) q.push_back(d);
    wcnt += ok_w;
    rcnt += ok_r;
    check_state(w && n == 16 && !r, r && n == 0);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    wcnt = 0;
    rcnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
    @(posedge clk); #1;
    model_reset();
    check_state(1'b0, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Fill to full, then one rejected write, then an idle cycle.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 8'h00);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Simultaneous wr/rd while empty, then while full.
    step(1'b1, 1'b1, 8'h33);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'h55);

    // Down to half occupancy, then random traffic across many wraps.
    while (q.size() > 8) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i < 200; i++) step(1'($urandom), 1'($urandom), 8'($urandom));

    // Asynchronous reset at count 9, between clock edges.
    while (q.size() < 9) step(1'b1, 1'b0, 8'($urandom));
    while (q.size() > 9) step(1'b0, 1'b1, 8'h00);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_state(1'b0, 1'b0);
    wr = 1'b1;
    #1;
    chk("w_en_in_reset", w_en, 1'b0);
    @(posedge clk); #1;
    check_state(1'b0, 1'b0);
    wr = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 8'h5C);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
